fdc_sector_locator: RTL and testbench

- Controller-side stage that consumes the virtual floppy drive outputs: dclk_en, track, sector, sector_hdr, sector_data, ready and index.
- On a command it waits for the drive to be ready and watches the passing headers for the requested track/sector.
- It then emits one byte strobe per data byte, with the byte offset within the sector.
- It reports record-not-found (RNF) after a fixed number of index pulses, as the WD1772 sector search does.

---
 rtl/fdc_sector_locator.sv | 197 +++++++++++++++++++
 tb/tb_fdc_sector_locator.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fdc_sector_locator.sv
// fdc_sector_locator: watches the drive's header stream for a requested
// track/sector, then strobes out the data bytes of that sector with their
// offsets. Gives up with RNF after INDEX_LIMIT revolutions, with not_ready
// if the drive never comes ready or drops ready mid-command.
module fdc_sector_locator #(
    parameter int CLK_EN           = 8000,
    parameter int INDEX_LIMIT      = 5,
    parameter int READY_TIMEOUT_MS = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk8m_en,
    input  logic        dclk_en,
    input  logic [6:0]  track,
    input  logic [5:0]  sector,
    input  logic        sector_hdr,
    input  logic        sector_data,
    input  logic        ready,
    input  logic        index,
    input  logic        cmd_start,
    input  logic        cmd_abort,
    input  logic [6:0]  target_track,
    input  logic [5:0]  target_sector,
    input  logic [10:0] sector_len,
    output logic        busy,
    output logic        byte_valid,
    output logic [9:0]  byte_addr,
    output logic        done,
    output logic        rnf,
    output logic        seek_err,
    output logic        not_ready
);
    localparam int            TMO_LIMIT = CLK_EN * READY_TIMEOUT_MS;
    localparam int            TW        = $clog2(TMO_LIMIT + 1);
    localparam logic [TW-1:0] TMO_END   = TW'(TMO_LIMIT);
    localparam logic [2:0]    IDX_END   = 3'(INDEX_LIMIT);

    typedef enum logic [2:0] {IDLE, WAIT_READY, WAIT_HDR, WAIT_DATA, DATA} state_t;

    state_t        state, state_d;
    logic [6:0]    trk_q, trk_d;
    logic [5:0]    sec_q, sec_d;
    logic [10:0]   len_q, len_d;
    logic [2:0]    idx_cnt, idx_d, idx_inc;
    logic [TW-1:0] tmo_cnt, tmo_d, tmo_inc;
    logic [10:0]   byte_cnt, cnt_d;
    logic [9:0]    addr_q, addr_d;
    logic          done_q, done_d;
    logic          rnf_q, rnf_d;
    logic          seek_q, seek_d;
    logic          nr_q, nr_d;
    logic          hdr_q, idx_q;
    logic          hdr_rise, idx_fall, last_byte;

    assign hdr_rise  = sector_hdr & ~hdr_q;
    assign idx_fall  = idx_q & ~index;
    assign idx_inc   = (idx_cnt == 3'd7) ? idx_cnt : idx_cnt + 3'd1;
    assign tmo_inc   = tmo_cnt + TW'(1);
    assign last_byte = (byte_cnt == len_q - 11'd1);

    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign rnf       = rnf_q;
    assign seek_err  = seek_q;
    assign not_ready = nr_q;
    // While a byte is being strobed show its offset, otherwise hold the last one.
    assign byte_addr = byte_valid ? byte_cnt[9:0] : addr_q;

    // State, command latches, counters, sticky flags and input edge detectors.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            trk_q    <= '0;
            sec_q    <= '0;
            len_q    <= '0;
            idx_cnt  <= '0;
            tmo_cnt  <= '0;
            byte_cnt <= '0;
            addr_q   <= '0;
            done_q   <= 1'b0;
            rnf_q    <= 1'b0;
            seek_q   <= 1'b0;
            nr_q     <= 1'b0;
            hdr_q    <= 1'b0;
            idx_q    <= 1'b1;   // index idles high
        end else begin
            state    <= state_d;
            trk_q    <= trk_d;
            sec_q    <= sec_d;
            len_q    <= len_d;
            idx_cnt  <= idx_d;
            tmo_cnt  <= tmo_d;
            byte_cnt <= cnt_d;
            addr_q   <= addr_d;
            done_q   <= done_d;
            rnf_q    <= rnf_d;
            seek_q   <= seek_d;
            nr_q     <= nr_d;
            hdr_q    <= sector_hdr;
            idx_q    <= index;
        end
    end

    // Next-state and byte strobe; abort beats ready loss beats header/index events.
    always_comb begin
        state_d    = state;
        trk_d      = trk_q;
        sec_d      = sec_q;
        len_d      = len_q;
        idx_d      = idx_cnt;
        tmo_d      = tmo_cnt;
        cnt_d      = byte_cnt;
        addr_d     = addr_q;
        done_d     = 1'b0;
        rnf_d      = rnf_q;
        seek_d     = seek_q;
        nr_d       = nr_q;
        byte_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_start) begin
                    trk_d   = target_track;
                    sec_d   = target_sector;
                    len_d   = sector_len;
                    rnf_d   = 1'b0;
                    seek_d  = 1'b0;
                    nr_d    = 1'b0;
                    idx_d   = '0;
                    tmo_d   = '0;
                    cnt_d   = '0;
                    addr_d  = '0;
                    state_d = WAIT_READY;
                end
            end
            WAIT_READY: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (ready) begin
                    state_d = WAIT_HDR;
                end else if (clk8m_en) begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_END) begin
                        nr_d    = 1'b1;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            WAIT_HDR: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (!ready) begin
                    nr_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (idx_fall) idx_d = idx_inc;
                    if (hdr_rise && sector == sec_q && track == trk_q) begin
                        state_d = WAIT_DATA;
                    end else begin
                        // Right sector on the wrong cylinder: the head is mispositioned.
                        if (hdr_rise && sector == sec_q) seek_d = 1'b1;
                        if (idx_fall && idx_inc == IDX_END) begin
                            rnf_d   = 1'b1;
                            done_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                end
            end
            WAIT_DATA, DATA: begin
                if (cmd_abort) begin
                    state_d = IDLE;
                end else if (!ready) begin
                    nr_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (state == DATA && !sector_data) begin
                    // Data field ended short of the requested length.
                    rnf_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    if (state == WAIT_DATA && idx_fall) idx_d = idx_inc;
                    if (dclk_en && sector_data) begin
                        byte_valid = 1'b1;
                        addr_d     = byte_cnt[9:0];
                        cnt_d      = byte_cnt + 11'd1;
                        state_d    = last_byte ? IDLE : DATA;
                        done_d     = last_byte;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fdc_sector_locator.sv
// tb_fdc_sector_locator: a byte-level rotating drive model feeds the locator;
// expected outcomes come from the drive geometry and the command.
module tb_fdc_sector_locator;
    localparam int CLK_EN      = 8000;
    localparam int INDEX_LIMIT = 5;
    localparam int TMO_MS      = 2;
    localparam int TMO         = CLK_EN * TMO_MS;

    logic        clk, reset, clk8m_en, dclk_en, sector_hdr, sector_data, ready, index;
    logic        cmd_start, cmd_abort, busy, byte_valid, done, rnf, seek_err, not_ready;
    logic [6:0]  track, target_track;
    logic [5:0]  sector, target_sector;
    logic [10:0] sector_len;
    logic [9:0]  byte_addr;

    int n_chk = 0, n_err = 0;
    // drive geometry
    int spt = 9, base = 1, dlen = 512, gap = 100, head_trk = 0, drv_sec = 0;
    bit restart = 0;
    // per-command observations
    int n_bytes, addr_err, src_err, overlap, done_cyc, last_cyc, edge_cyc, strb_cyc, busy1;

    fdc_sector_locator #(.CLK_EN(CLK_EN), .INDEX_LIMIT(INDEX_LIMIT), .READY_TIMEOUT_MS(TMO_MS)) dut (
        .clk(clk), .reset(reset), .clk8m_en(clk8m_en), .dclk_en(dclk_en),
        .track(track), .sector(sector), .sector_hdr(sector_hdr), .sector_data(sector_data),
        .ready(ready), .index(index), .cmd_start(cmd_start), .cmd_abort(cmd_abort),
        .target_track(target_track), .target_sector(target_sector), .sector_len(sector_len),
        .busy(busy), .byte_valid(byte_valid), .byte_addr(byte_addr), .done(done),
        .rnf(rnf), .seek_err(seek_err), .not_ready(not_ready)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    // Time base with random gaps so the timeout counts strobes, not cycles.
    initial begin
        clk8m_en = 0;
        forever begin
            @(posedge clk); #1;
            clk8m_en = ($urandom_range(0, 7) != 0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One byte cell: two clocks, dclk_en high for the first.
    task automatic drv_byte(input bit hdr, input bit dat, input bit idx);
        @(posedge clk); #1;
        sector_hdr = hdr; sector_data = dat; index = !idx; dclk_en = 1'b1;
        @(posedge clk); #1;
        dclk_en = 1'b0;
    endtask

    task automatic drv_rev();
        for (int i = 0; i < 4; i++) drv_byte(0, 0, 1);
        for (int i = 0; i < gap && !restart; i++) drv_byte(0, 0, 0);
        for (int s = 0; s < spt && !restart; s++) begin
            drv_sec = base + s;
            track   = 7'(head_trk);
            sector  = 6'(base + s);
            for (int i = 0; i < 6 && !restart; i++) drv_byte(1, 0, 0);
            for (int i = 0; i < gap && !restart; i++) drv_byte(0, 0, 0);
            for (int i = 0; i < dlen && !restart; i++) drv_byte(0, 1, 0);
            for (int i = 0; i < gap && !restart; i++) drv_byte(0, 0, 0);
        end
    endtask

    initial begin
        dclk_en = 0; sector_hdr = 0; sector_data = 0; index = 1; track = 0; sector = 0;
        forever begin
            restart = 0;
            drv_rev();
        end
    end

    // Change geometry and restart the rotation at the index hole.
    task automatic regeom(input int s, input int d, input int g);
        spt = s; dlen = d; gap = g; restart = 1;
        for (int i = 0; i < 64 && restart; i++) @(negedge clk);
    endtask

    // Outcome implied by the geometry: bytes delivered, rnf, seek_err.
    function automatic void ref_cmd(input int trk, input int sec, input int len,
                                    output int eb, output bit erf, output bit esk);
        bit present, on_trk;
        present = (sec >= base) && (sec < base + spt);
        on_trk  = (trk == head_trk);
        eb  = (present && on_trk) ? ((len <= dlen) ? len : dlen) : 0;
        erf = !(present && on_trk) || (len > dlen);
        esk = present && !on_trk;
    endfunction

    // Issue a command and observe until done, budget expiry, or byte stop_at.
    task automatic run_cmd(input int trk, input int sec, input int len, input int budget, input int stop_at);
        int nidx, nstrb, c;
        logic prev_idx;
        logic [9:0] exp_addr;
        bit stop;
        n_bytes = 0; addr_err = 0; src_err = 0; overlap = 0; busy1 = 0;
        done_cyc = -1; last_cyc = -1; edge_cyc = -1; strb_cyc = -1;
        nidx = 0; nstrb = 0; stop = 0; exp_addr = '0; c = 0;
        @(negedge clk);
        target_track = 7'(trk); target_sector = 6'(sec); sector_len = 11'(len);
        cmd_start = 1;
        prev_idx = index;
        while (c < budget && !stop) begin
            @(negedge clk);
            c++;
            if (c == 1) begin
                cmd_start = 0;
                busy1 = busy;
            end
            // an edge arriving while ready is still being confirmed is not counted
            if (c >= 2 && prev_idx && !index) begin
                nidx++;
                if (nidx == INDEX_LIMIT) edge_cyc = c;
            end
            prev_idx = index;
            if (clk8m_en) begin
                nstrb++;
                if (nstrb == TMO) strb_cyc = c;
            end
            if (byte_valid) begin
                if (byte_addr != exp_addr) addr_err++;
                if (!dclk_en || !sector_data || drv_sec != sec || head_trk != trk) src_err++;
                if (done) overlap++;
                n_bytes++; exp_addr++; last_cyc = c;
                if (stop_at >= 0 && int'(byte_addr) == stop_at) stop = 1;
            end
            if (done) begin
                done_cyc = c;
                stop = 1;
            end
        end
        cmd_start = 0;
    endtask

    task automatic chk_run(input string pfx, input int trk, input int sec, input int len);
        int eb;
        bit erf, esk;
        ref_cmd(trk, sec, len, eb, erf, esk);
        chk({pfx, "_done_seen"}, done_cyc > 0, 1);
        chk({pfx, "_bytes"}, n_bytes, eb);
        chk({pfx, "_rnf"}, rnf, erf);
        chk({pfx, "_seek"}, seek_err, esk);
    endtask

    initial begin
        int sec, nbv, ndn;
        reset = 1; cmd_start = 0; cmd_abort = 0; ready = 1;
        target_track = 0; target_sector = 0; sector_len = 0;
        repeat (4) @(negedge clk);
        chk("reset_outs", {busy, byte_valid, byte_addr, done, rnf, seek_err, not_ready}, 0);
        reset = 0;
        repeat ($urandom_range(20, 1000)) @(negedge clk);

        // full 512-byte read of track 0 sector 3
        run_cmd(0, 3, 512, 30000, -1);
        chk("rd_busy_next", busy1, 1);
        chk_run("rd", 0, 3, 512);
        chk("rd_addr_seq", addr_err, 0);
        chk("rd_src", src_err, 0);
        chk("rd_done_with_byte", overlap, 0);
        chk("rd_done_lat", done_cyc - last_cyc, 1);
        chk("rd_nr", not_ready, 0);

        // missing sector -> rnf after INDEX_LIMIT revolutions
        regeom(9, 32, 4);
        sec = $urandom_range(10, 63);
        run_cmd(0, sec, 128, 12000, -1);
        chk_run("rnf", 0, sec, 128);
        chk("rnf_done_lat", done_cyc - edge_cyc, 1);

        // head on track 2, request track 5
        head_trk = 2;
        sec = $urandom_range(1, 9);
        run_cmd(5, sec, 128, 12000, -1);
        chk_run("seek", 5, sec, 128);
        chk("seek_done_lat", done_cyc - edge_cyc, 1);

        // motor off -> not_ready after TMO strobes
        head_trk = 0;
        ready = 0;
        run_cmd(0, 1, 128, 25000, -1);
        chk("tmo_done_seen", done_cyc > 0, 1);
        chk("tmo_nr", not_ready, 1);
        chk("tmo_rnf", rnf, 0);
        chk("tmo_done_lat", done_cyc - strb_cyc, 1);
        ready = 1;

        // abort after byte 100
        regeom(9, 128, 4);
        sec = $urandom_range(1, 9);
        run_cmd(0, sec, 128, 8000, 100);
        chk("ab_bytes", n_bytes, 101);
        chk("ab_addr_seq", addr_err, 0);
        @(negedge clk); cmd_abort = 1;
        @(negedge clk); cmd_abort = 0;
        chk("ab_busy", busy, 0);
        nbv = 0; ndn = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (byte_valid) nbv++;
            if (done) ndn++;
        end
        chk("ab_no_bytes", nbv, 0);
        chk("ab_no_done", ndn, 0);
        chk("ab_flags", {rnf, seek_err, not_ready}, 0);

        // reset mid-data, then a full 1024-byte read
        regeom(3, 1024, 10);
        sec = $urandom_range(1, 3);
        run_cmd(0, sec, 1024, 12000, 200);
        chk("rs_pre_bytes", n_bytes, 201);
        reset = 1;
        #1;
        chk("rs_outs", {busy, byte_valid, byte_addr, done, rnf, seek_err, not_ready}, 0);
        @(negedge clk); reset = 0;
        sec = $urandom_range(1, 3);
        run_cmd(0, sec, 1024, 14000, -1);
        chk_run("rd1k", 0, sec, 1024);
        chk("rd1k_addr_seq", addr_err, 0);
        chk("rd1k_src", src_err, 0);
        chk("rd1k_done_lat", done_cyc - last_cyc, 1);
        chk("rd1k_nr", not_ready, 0);
        repeat (5) @(negedge clk);
        chk("rd1k_addr_hold", byte_addr, 1023);
        chk("rd1k_idle", busy, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
